// File: rtl/not_neg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : not_neg_sequencer
// Brief    : Hardwired fetch/decode/execute controller for the NOT/NEG
//            register-to-register datapath; counts retirements, traps bad opcodes.
// Revision : 1.0  initial release
// ============================================================================
module not_neg_sequencer #(
    parameter logic [4:0] OP_NEG = 5'b10000,
    parameter logic [4:0] OP_NOT = 5'b10001
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir_in,
    output logic        pc_out,
    output logic        mdr_out,
    output logic        zlo_out,
    output logic [15:0] r_out,
    output logic        mar_in,
    output logic        pc_increment,
    output logic        mdr_read,
    output logic        mdr_enable,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        zlo_enable,
    output logic [15:0] r_enable,
    output logic [4:0]  op_code,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [7:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    state_t      r_state_q;
    state_t      w_state_d;
    logic        r_illegal_q;
    logic        w_illegal_d;
    logic [7:0]  r_retired_q;
    logic [7:0]  w_retired_d;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic        w_legal;
    logic        w_ir_unused;

    assign w_opcode    = ir_in[31:27];
    assign w_ra        = ir_in[26:23];
    assign w_rb        = ir_in[22:19];
    assign w_ir_unused = ^ir_in[18:0];
    assign w_legal     = (w_opcode == OP_NEG) || (w_opcode == OP_NOT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state_q   <= S_IDLE;
            r_illegal_q <= 1'b0;
            r_retired_q <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_illegal_q <= w_illegal_d;
            r_retired_q <= w_retired_d;
        end
    end

    // Strobes decode from the registered state only, so an async clr drops them at once.
    always_comb begin
        w_state_d    = r_state_q;
        w_illegal_d  = r_illegal_q;
        w_retired_d  = r_retired_q;
        pc_out       = 1'b0;
        mdr_out      = 1'b0;
        zlo_out      = 1'b0;
        r_out        = 16'd0;
        mar_in       = 1'b0;
        pc_increment = 1'b0;
        mdr_read     = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        zlo_enable   = 1'b0;
        r_enable     = 16'd0;
        op_code      = 5'd0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_T0;
                end
            end
            S_T0: begin
                busy         = 1'b1;
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                pc_increment = 1'b1;
                w_state_d    = S_T1;
            end
            S_T1: begin
                busy       = 1'b1;
                mdr_read   = 1'b1;
                mdr_enable = 1'b1;
                if (mem_ready) begin
                    w_state_d = S_T2;
                end
            end
            S_T2: begin
                busy      = 1'b1;
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
                w_state_d = S_T3;
            end
            S_T3: begin
                busy = 1'b1;
                if (w_legal) begin
                    r_out      = 16'd1 << w_rb;
                    op_code    = w_opcode;
                    zlo_enable = 1'b1;
                    w_state_d  = S_T4;
                end else begin
                    w_illegal_d = 1'b1;
                    w_state_d   = S_FAULT;
                end
            end
            S_T4: begin
                busy      = 1'b1;
                zlo_out   = 1'b1;
                r_enable  = 16'd1 << w_ra;
                w_state_d = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_retired_d = r_retired_q + 8'd1;
                w_state_d   = start ? S_T0 : S_IDLE;
            end
            S_FAULT: begin
                w_state_d = S_FAULT;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign illegal = r_illegal_q;
    assign retired = r_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_not_neg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_not_neg_sequencer
// Brief    : Self-checking bench: datapath model, scoreboard of retirements.
// Revision : 1.0  initial release
// ============================================================================
module tb_not_neg_sequencer;

    localparam logic [4:0] C_OP_NEG = 5'b10000;
    localparam logic [4:0] C_OP_NOT = 5'b10001;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir_in;
    logic        pc_out, mdr_out, zlo_out;
    logic [15:0] r_out;
    logic        mar_in, pc_increment, mdr_read, mdr_enable, ir_enable, y_enable, zlo_enable;
    logic [15:0] r_enable;
    logic [4:0]  op_code;
    logic        busy, done, illegal;
    logic [7:0]  retired;

    not_neg_sequencer #(.OP_NEG(C_OP_NEG), .OP_NOT(C_OP_NOT)) dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir_in(ir_in),
        .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .r_out(r_out),
        .mar_in(mar_in), .pc_increment(pc_increment), .mdr_read(mdr_read),
        .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
        .zlo_enable(zlo_enable), .r_enable(r_enable), .op_code(op_code),
        .busy(busy), .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- datapath environment ----------------
    logic [31:0] dp_r [16];
    logic [31:0] dp_pc, dp_mar, dp_mdr, dp_ir, dp_z;
    logic [31:0] mem [512];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'd0;
    logic        pc_clr = 1'b1;
    logic [31:0] bus;

    always_comb begin
        bus = 32'd0;
        if (pc_out)  bus = bus | dp_pc;
        if (mdr_out) bus = bus | dp_mdr;
        if (zlo_out) bus = bus | dp_z;
        for (int i = 0; i < 16; i++)
            if (r_out[i]) bus = bus | dp_r[i];
    end

    always @(posedge clk) begin
        if (mar_in) dp_mar <= bus;
        if (pc_clr) dp_pc <= 32'd0;
        else if (pc_increment) dp_pc <= dp_pc + 32'd1;
        if (mdr_enable) dp_mdr <= mdr_read ? (mem_ready ? mem[dp_mar[8:0]] : 32'hDEAD_BEEF) : bus;
        if (ir_enable) dp_ir <= bus;
        if (zlo_enable) begin
            case (op_code)
                C_OP_NEG: dp_z <= 32'd0 - bus;
                C_OP_NOT: dp_z <= ~bus;
                default:  dp_z <= bus;
            endcase
        end
        for (int i = 0; i < 16; i++)
            if (r_enable[i]) dp_r[i] <= bus;
        if (pl_en) dp_r[pl_idx] <= pl_val;
    end

    assign ir_in = dp_ir;

    // ---------------- memory wait-state driver ----------------
    int stall_q[$];
    initial begin
        int stall_left;
        bit in_t1;
        stall_left = 0;
        in_t1 = 1'b0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mdr_read) begin
                if (!in_t1) begin
                    in_t1 = 1'b1;
                    stall_left = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
                end
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                in_t1 = 1'b0;
                mem_ready = 1'($urandom);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          ra;
        logic [31:0] val;
        logic [7:0]  ret;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_r [16];
    logic [7:0]  model_ret = 8'd0;
    int          pc_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [48:0] sig();
        return {pc_out, mdr_out, zlo_out, mar_in, pc_increment, mdr_read, mdr_enable,
                ir_enable, y_enable, zlo_enable, busy, done, r_out, r_enable, op_code};
    endfunction

    // Expected strobe vector for execution step 0..5 (T0..T4, DONE).
    function automatic logic [48:0] exp_sig(input int step, input int ra, input int rb,
                                            input logic [4:0] op);
        logic pco, mdo, zo, mi, pci, mr, me, ie, ze, dn;
        logic [15:0] ro, re;
        logic [4:0]  oc;
        {pco, mdo, zo, mi, pci, mr, me, ie, ze, dn} = 10'd0;
        ro = 16'd0; re = 16'd0; oc = 5'd0;
        case (step)
            0: begin pco = 1'b1; mi = 1'b1; pci = 1'b1; end
            1: begin mr = 1'b1; me = 1'b1; end
            2: begin mdo = 1'b1; ie = 1'b1; end
            3: begin ro = 16'd1 << rb; oc = op; ze = 1'b1; end
            4: begin zo = 1'b1; re = 16'd1 << ra; end
            default: dn = 1'b1;
        endcase
        return {pco, mdo, zo, mi, pci, mr, me, ie, 1'b0, ze, 1'b1, dn, ro, re, oc};
    endfunction

    function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] v);
        return (op == C_OP_NEG) ? (32'd0 - v) : ~v;
    endfunction

    initial begin
        exp_t e;
        bit   inv_ok;
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("dest_value", dp_r[e.ra], e.val);
                    check("retired_at_done", retired, e.ret);
                end
            end
            inv_ok = ($countones({pc_out, mdr_out, zlo_out, r_out}) <= 1) && !y_enable &&
                     ($countones(r_enable) == int'(zlo_out)) &&
                     ((op_code == 5'd0) || zlo_enable);
            check("strobe_invariants", inv_ok, 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_reg(input int idx, input logic [31:0] v);
        pl_en  = 1'b1;
        pl_idx = idx[3:0];
        pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
        model_r[idx] = v;
    endtask

    task automatic issue(input logic [4:0] op, input int ra, input int rb, input int stall,
                         input longint exp_cyc, input bit push);
        exp_t e;
        mem[pc_model[8:0]] = {op, ra[3:0], rb[3:0], 19'($urandom)};
        pc_model++;
        stall_q.push_back(stall);
        if (push) begin
            model_r[ra] = ref_op(op, model_r[rb]);
            e.ra  = ra;
            e.val = model_r[ra];
            e.ret = model_ret;
            e.cyc = exp_cyc;
            model_ret = model_ret + 8'd1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) begin
            check("drain_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_until_done(input int n, input int budget);
        int seen, k;
        seen = 0;
        k = 0;
        start = 1'b1;
        while (seen < n && k < budget) begin
            @(negedge clk);
            k++;
            if (done) seen++;
            if (seen == n) start = 1'b0;
        end
        start = 1'b0;
        if (seen < n) check("batch_timeout", seen, n);
        wait_idle(50);
    endtask

    task automatic run_batch(input int n, input int max_stall);
        longint c, acc;
        int s;
        logic [4:0] op;
        c = cyc;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            s = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            acc += 6 + s;
            op = $urandom_range(0, 1) ? C_OP_NEG : C_OP_NOT;
            issue(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), s, c + acc, 1'b1);
        end
        run_until_done(n, 10 * n + 20);
    endtask

    initial begin
        longint c;
        int     s, n;
        logic [7:0] ret_before;

        clr = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", sig(), 49'd0);
        check("reset_flags", {illegal, retired}, 9'd0);
        clr = 1'b0;
        pc_clr = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {sig(), illegal, retired}, 58'd0);

        for (int i = 0; i < 16; i++) set_reg(i, $urandom);

        // NEG R1, R2 with a full strobe trace
        set_reg(2, 32'h0000_0005);
        c = cyc;
        issue(C_OP_NEG, 1, 2, 0, c + 6, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("trace_step%0d", k), sig(), exp_sig(k, 1, 2, C_OP_NEG));
        end
        wait_idle(20);
        check("neg_r1", dp_r[1], 32'hFFFF_FFFB);
        check("retired_one", retired, 8'd1);
        check("pc_incremented", dp_pc, 32'd1);

        // NOT R3, R3 with three wait states
        set_reg(3, 32'h0F0F_0F0F);
        c = cyc;
        issue(C_OP_NOT, 3, 3, 3, c + 9, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(30);
        check("not_r3", dp_r[3], 32'hF0F0_F0F0);

        // Illegal opcode traps and holds FAULT
        s = int'($urandom_range(0, 2));
        ret_before = model_ret;
        issue(5'b00011, 4, 5, s, 0, 1'b0);
        start = 1'b1;
        repeat (4 + s) @(negedge clk);
        check("illegal_t3", sig(), {12'h002, 37'd0});
        @(negedge clk);
        check("illegal_set", {illegal, busy}, 2'b10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("fault_hold", {sig(), illegal, retired}, {49'd0, 1'b1, ret_before});
        end
        clr = 1'b1;
        #1;
        check("fault_cleared", {sig(), illegal, retired}, 58'd0);
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        model_ret = 8'd0;
        @(negedge clk);

        // Three back-to-back NEGs, no wait states
        c = cyc;
        for (int k = 0; k < 3; k++)
            issue(C_OP_NEG, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0,
                  c + 6 * (k + 1), 1'b1);
        run_until_done(3, 60);
        check("retired_three", retired, 8'd3);

        // Randomized back-to-back mix with wait states
        run_batch(20, 3);
        for (int i = 0; i < 16; i++)
            check($sformatf("regfile_r%0d", i), dp_r[i], model_r[i]);

        // clr during T4 must suppress the register write
        c = cyc;
        issue(C_OP_NEG, 5, 6, 0, 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_reached", {zlo_out, r_enable}, {1'b1, 16'h0020});
        clr = 1'b1;
        #1;
        check("clr_t4_outputs", {sig(), illegal, retired}, 58'd0);
        @(negedge clk);
        clr = 1'b0;
        model_ret = 8'd0;
        @(negedge clk);
        check("r5_not_written", dp_r[5], model_r[5]);

        c = cyc;
        issue(C_OP_NOT, 5, 6, 1, c + 7, 1'b1);
        run_until_done(1, 40);
        check("after_clr_run", dp_r[5], model_r[5]);

        // Retire until the counter wraps to 0
        n = 256 - int'(model_ret);
        run_batch(n, 1);
        check("retired_wrap", retired, 8'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("final_r%0d", i), dp_r[i], model_r[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/not_neg_sequencer.md
# not_neg_sequencer

Hardwired control unit for the NOT/NEG register-to-register datapath. It fetches each instruction into IR, decodes the 5-bit opcode and register fields, and runs the execute steps. It drives every datapath control strobe (bus-source selects, register enables, MDR path, ALU op_code) so a bench or top level only supplies memory data and a start request. It also counts retired instructions and traps illegal opcodes.

## Interface
Parameters
- OP_NEG, 5'b10000, opcode for neg Ra, Rb (Ra <= -Rb)
- OP_NOT, 5'b10001, opcode for not Ra, Rb (Ra <= ~Rb)

Ports
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-high reset
- start  in  1  level request to run instructions
- mem_ready  in  1  memory read data valid on datapath data_in
- ir_in  in  32  current IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb
- pc_out, mdr_out, zlo_out  out  1 each  bus-source selects, at most one high per cycle
- r_out  out  16  one-hot GPR bus-source select
- mar_in, pc_increment, mdr_read, mdr_enable, ir_enable, y_enable, zlo_enable  out  1 each  datapath strobes
- r_enable  out  16  one-hot GPR load enable
- op_code  out  5  ALU operation
- busy  out  1  high in any state except IDLE and FAULT
- done  out  1  one-cycle pulse per retired instruction
- illegal  out  1  sticky illegal-opcode flag
- retired  out  8  retired-instruction count

## Operation
- States: IDLE, T0, T1, T2, T3, T4, DONE, FAULT. The state register uses an async reset to IDLE.
- Outputs are Moore-decoded from the state. r_out and r_enable also decode ir_in. Each strobe is asserted for its whole state cycle and takes effect at the closing rising edge. All strobes not listed for a state are 0.
- IDLE: no strobes. Go to T0 when start=1.
- T0: pc_out, mar_in, pc_increment. Go to T1.
- T1: mdr_read, mdr_enable. Stay in T1 while mem_ready=0; the MDR reloads each cycle, which is harmless. Go to T2 when mem_ready=1.
- T2: mdr_out, ir_enable. Go to T3.
- T3 (sees the new IR):
  - If opcode is OP_NEG or OP_NOT: r_out[Rb]=1, op_code=opcode, zlo_enable. Go to T4.
  - Otherwise: no strobes, op_code=0, set illegal, go to FAULT.
- T4: zlo_out, r_enable[Ra]=1. Go to DONE.
- DONE: done=1, retired increments by 1 (modulo 256, 255 wraps to 0). Go to T0 if start=1, else IDLE.
- FAULT: no strobes, busy=0, illegal=1. Leave only via clr.
- Register fields:
  - Ra and Rb use bits [26:23] and [22:19], 4 bits each.
  - Ra=Rb is legal: Rb is read in T3 and Ra written in T4.
  - IR bits [18:0] are ignored.
- y_enable is always 0. It is kept for later binary-op expansion.
- op_code is 0 in every state except T3.

## Timing
- Reset values: state IDLE, all strobes 0, r_out and r_enable 0, op_code 0, busy 0, done 0, illegal 0, retired 0.
- clr takes effect immediately, from any state including mid-T1 stall. No partial register write may follow it: r_enable drops with the state.
- Latency with mem_ready high throughout:
  - 5 busy cycles (T0 to T4) plus DONE, so 6 cycles from start sampled to done.
  - Back-to-back instructions issue every 6 cycles.
- Each cycle of mem_ready=0 in T1 adds exactly 1 cycle.
- mem_ready is ignored outside T1.
- start is sampled only in IDLE and DONE. Dropping start mid-instruction does not abort it.
- retired and done change only on DONE. They never change on illegal opcodes.

## Test plan
- Reset then NEG: preload R2=32'h00000005, memory word {OP_NEG, Ra=1, Rb=2, 19'b0}, start=1 for one cycle, mem_ready=1 -> state sequence T0..T4, DONE; done at cycle 6; R1=32'hFFFFFFFB; retired=1; PC incremented by 1.
- NOT with stall: R3=32'h0F0F0F0F, word {OP_NOT, Ra=3, Rb=3}, mem_ready low for 3 cycles in T1 -> T1 held 4 cycles; R3=32'hF0F0F0F0; done at cycle 9.
- Illegal opcode 5'b00011 -> in T3 no r_out/r_enable strobes; illegal=1; FAULT held for 20 cycles with start=1; retired unchanged; clr clears illegal and returns to IDLE.
- Back-to-back: start held high, 3 NEG words -> done pulses at cycles 6, 12, 18; retired=3; r_enable exactly one-hot in each T4 and 0 elsewhere.
- clr asserted mid-T4 -> all outputs 0 in the same cycle; destination register not written; next start runs normally.
- Counter wrap: retire 256 instructions -> retired reads 255 then 0; done pulses every instruction.
